// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_fifo
//  Purpose  : 8N1 UART transmitter fed by a small byte FIFO (valid/ready in).
//             Define UART_TX_PARITY_EN to add an even-parity bit per frame.
//  Revision : 1.0
// ============================================================================
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 100,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [7:0]                    data,
    input  logic                          valid,
    output logic                          ready,
    output logic                          TX,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   level
);
    localparam int              c_AW        = $clog2(FIFO_DEPTH);
    localparam int              c_BW        = $clog2(CLKS_PER_BIT);
    localparam logic [c_BW-1:0] c_BAUD_LAST = c_BW'(CLKS_PER_BIT - 1);
    localparam logic [c_AW:0]   c_FULL      = (c_AW + 1)'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        c_IDLE = 3'd0, c_START = 3'd1, c_DATA = 3'd2, c_PARITY = 3'd3, c_STOP = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        c_IDLE = 3'd0, c_START = 3'd1, c_DATA = 3'd2, c_STOP = 3'd4
    } state_t;
`endif

    state_t            r_state_q, w_state_d;
    logic [c_BW-1:0]   r_baud_q,  w_baud_d;
    logic [2:0]        r_bit_q,   w_bit_d;
    logic [7:0]        r_shift_q, w_shift_d;
    logic              r_tx_q,    w_tx_d;
    logic              r_busy_q,  w_busy_d;
    logic [c_AW-1:0]   r_wr_q,    w_wr_d;
    logic [c_AW-1:0]   r_rd_q,    w_rd_d;
    logic [c_AW:0]     r_level_q, w_level_d;
`ifdef UART_TX_PARITY_EN
    logic              r_par_q,   w_par_d;
`endif
    logic [7:0]        r_mem [FIFO_DEPTH];

    logic w_baud_end;
    logic w_pop;
    logic w_push;

    assign w_baud_end = (r_baud_q == c_BAUD_LAST);
    assign w_pop      = (r_level_q != '0) &&
                        ((r_state_q == c_IDLE) || ((r_state_q == c_STOP) && w_baud_end));
    // A pop on this edge frees a slot, so a full FIFO may still take a byte.
    assign ready      = !RST && ((r_level_q != c_FULL) || w_pop);
    assign w_push     = valid && ready;

    always_comb begin
        w_state_d = r_state_q;
        w_baud_d  = w_baud_end ? '0 : r_baud_q + c_BW'(1);
        w_bit_d   = r_bit_q;
        w_shift_d = r_shift_q;
        w_tx_d    = r_tx_q;
        w_busy_d  = r_busy_q;
        w_wr_d    = r_wr_q;
        w_rd_d    = r_rd_q;
        w_level_d = r_level_q;
`ifdef UART_TX_PARITY_EN
        w_par_d   = r_par_q;
`endif
        case (r_state_q)
            c_IDLE: begin
                w_baud_d = '0;
                if (w_pop) begin
                    w_tx_d    = 1'b0;
                    w_busy_d  = 1'b1;
                    w_state_d = c_START;
                end
            end
            c_START: begin
                if (w_baud_end) begin
                    w_tx_d    = r_shift_q[0];
                    w_shift_d = {1'b0, r_shift_q[7:1]};
                    w_bit_d   = '0;
                    w_state_d = c_DATA;
                end
            end
            c_DATA: begin
                if (w_baud_end) begin
                    if (r_bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        w_tx_d    = r_par_q;
                        w_state_d = c_PARITY;
`else
                        w_tx_d    = 1'b1;
                        w_state_d = c_STOP;
`endif
                    end else begin
                        w_tx_d    = r_shift_q[0];
                        w_shift_d = {1'b0, r_shift_q[7:1]};
                        w_bit_d   = r_bit_q + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            c_PARITY: begin
                if (w_baud_end) begin
                    w_tx_d    = 1'b1;
                    w_state_d = c_STOP;
                end
            end
`endif
            c_STOP: begin
                if (w_baud_end) begin
                    if (w_pop) begin
                        w_tx_d    = 1'b0;
                        w_state_d = c_START;
                    end else begin
                        w_busy_d  = 1'b0;
                        w_state_d = c_IDLE;
                    end
                end
            end
            default: begin
                w_state_d = c_IDLE;
            end
        endcase

        if (w_pop) begin
            w_shift_d = r_mem[r_rd_q];
            w_rd_d    = r_rd_q + c_AW'(1);
`ifdef UART_TX_PARITY_EN
            w_par_d   = ^r_mem[r_rd_q];
`endif
        end
        if (w_push) begin
            w_wr_d = r_wr_q + c_AW'(1);
        end
        case ({w_push, w_pop})
            2'b10:   w_level_d = r_level_q + (c_AW + 1)'(1);
            2'b01:   w_level_d = r_level_q - (c_AW + 1)'(1);
            default: w_level_d = r_level_q;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state_q <= c_IDLE;
            r_baud_q  <= '0;
            r_bit_q   <= '0;
            r_shift_q <= '0;
            r_tx_q    <= 1'b1;
            r_busy_q  <= 1'b0;
            r_wr_q    <= '0;
            r_rd_q    <= '0;
            r_level_q <= '0;
`ifdef UART_TX_PARITY_EN
            r_par_q   <= 1'b0;
`endif
        end else begin
            r_state_q <= w_state_d;
            r_baud_q  <= w_baud_d;
            r_bit_q   <= w_bit_d;
            r_shift_q <= w_shift_d;
            r_tx_q    <= w_tx_d;
            r_busy_q  <= w_busy_d;
            r_wr_q    <= w_wr_d;
            r_rd_q    <= w_rd_d;
            r_level_q <= w_level_d;
`ifdef UART_TX_PARITY_EN
            r_par_q   <= w_par_d;
`endif
        end
    end

    // Storage needs no reset: ready is low under RST, so nothing is written.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wr_q] <= data;
        end
    end

    assign TX    = r_tx_q;
    assign busy  = r_busy_q;
    assign level = r_level_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_fifo
//  Purpose  : Self-checking bench for uart_tx_fifo against a line-level model.
//  Revision : 1.0
// ============================================================================
module tb_uart_tx_fifo;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic       CLK   = 1'b0;
    logic       RST   = 1'b1;
    logic [7:0] data  = 8'h00;
    logic       valid = 1'b0;
    logic       ready;
    logic       TX;
    logic       busy;
    logic [2:0] level;

    int total = 0;
    int bad   = 0;

    // Model: bytes waiting in the FIFO, and the per-cycle line values still to be sent.
    logic [7:0] mq[$];
    logic       lq[$];
    logic       m_tx, m_busy, m_rdy, m_acc, obs_rdy;
    logic [2:0] m_level;

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST(RST), .data(data), .valid(valid),
        .ready(ready), .TX(TX), .busy(busy), .level(level)
    );

    always #5 CLK = ~CLK;

    function automatic logic frame_bit(input logic [7:0] b, input int i);
        if (i == 0)         return 1'b0;
        if (i <= 8)         return b[i-1];
        if (i == NBITS - 1) return 1'b1;
        return ^b;
    endfunction

    // One clock: drive inputs, record DUT ready before the edge, advance the model.
    task automatic step(input logic v, input logic [7:0] d, input logic r);
        logic       pop;
        logic [7:0] b;
        valid = v; data = d; RST = r;
        #1;
        obs_rdy = ready;
        pop   = !r && (lq.size() == 0) && (mq.size() > 0);
        m_rdy = !r && ((mq.size() < DEPTH) || pop);
        m_acc = v && m_rdy;
        @(posedge CLK); #1;
        if (r) begin
            mq.delete();
            lq.delete();
        end else begin
            if (pop) begin
                b = mq.pop_front();
                for (int i = 0; i < NBITS; i++)
                    for (int k = 0; k < CPB; k++) lq.push_back(frame_bit(b, i));
            end
            if (m_acc) mq.push_back(d);
        end
        if (lq.size() > 0) begin m_tx = lq.pop_front(); m_busy = 1'b1; end
        else               begin m_tx = 1'b1;           m_busy = 1'b0; end
        m_level = 3'(mq.size());
    endtask

    task automatic test_reset();
        for (int c = 0; c < 3; c++) begin
            step(1'b0, 8'h00, 1'b1);
            total++; if (obs_rdy !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", obs_rdy); end
            total++; if (TX !== 1'b1)      begin bad++; $display("FAIL reset_tx got=%b want=1", TX); end
            total++; if (busy !== 1'b0)    begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
            total++; if (level !== 3'd0)   begin bad++; $display("FAIL reset_level got=%0d want=0", level); end
        end
        step(1'b0, 8'h00, 1'b0);
        total++; if (obs_rdy !== 1'b1) begin bad++; $display("FAIL reset_ready_after got=%b want=1", obs_rdy); end
    endtask

    task automatic test_single();
        step(1'b1, 8'h62, 1'b0);
        total++; if (level !== 3'd1) begin bad++; $display("FAIL single_level got=%0d want=1", level); end
        step(1'b0, 8'h00, 1'b0);
        total++; if (TX !== 1'b0) begin bad++; $display("FAIL single_latency got=%b want=0", TX); end
        for (int c = 0; c < NBITS * CPB + 6; c++) begin
            step(1'b0, 8'h00, 1'b0);
            total++; if (TX !== m_tx)     begin bad++; $display("FAIL single_tx cyc=%0d got=%b want=%b", c, TX, m_tx); end
            total++; if (busy !== m_busy) begin bad++; $display("FAIL single_busy cyc=%0d got=%b want=%b", c, busy, m_busy); end
        end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_done got=%b want=0", busy); end
    endtask

    task automatic test_back_to_back();
        step(1'b1, 8'h55, 1'b0);
        step(1'b1, 8'hAA, 1'b0);
        total++; if (level !== 3'd1) begin bad++; $display("FAIL b2b_level_pop1 got=%0d want=1", level); end
        for (int c = 0; c < 2 * NBITS * CPB + 6; c++) begin
            step(1'b0, 8'h00, 1'b0);
            total++; if (TX !== m_tx)       begin bad++; $display("FAIL b2b_tx cyc=%0d got=%b want=%b", c, TX, m_tx); end
            total++; if (level !== m_level) begin bad++; $display("FAIL b2b_level cyc=%0d got=%0d want=%0d", c, level, m_level); end
            total++; if (busy !== m_busy)   begin bad++; $display("FAIL b2b_busy cyc=%0d got=%b want=%b", c, busy, m_busy); end
        end
    endtask

    task automatic test_full();
        int acc = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 8'h10 + 8'(i * 17), 1'b0);
            if (obs_rdy === 1'b1) acc++;
            total++; if (obs_rdy !== m_rdy)  begin bad++; $display("FAIL full_ready i=%0d got=%b want=%b", i, obs_rdy, m_rdy); end
            total++; if (level !== m_level)  begin bad++; $display("FAIL full_level i=%0d got=%0d want=%0d", i, level, m_level); end
        end
        total++; if (acc != 5)       begin bad++; $display("FAIL full_accepted got=%0d want=5", acc); end
        total++; if (level !== 3'd4) begin bad++; $display("FAIL full_peak got=%0d want=4", level); end
    endtask

    task automatic test_full_pop();
        logic done = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            step(1'b1, 8'hC3, 1'b0);
            total++; if (obs_rdy !== m_rdy) begin bad++; $display("FAIL fullpop_ready cyc=%0d got=%b want=%b", c, obs_rdy, m_rdy); end
            total++; if (TX !== m_tx)       begin bad++; $display("FAIL fullpop_tx cyc=%0d got=%b want=%b", c, TX, m_tx); end
            if (m_acc) begin
                done = 1'b1;
                total++; if (level !== 3'd4) begin bad++; $display("FAIL fullpop_level got=%0d want=4", level); end
            end
        end
        total++; if (!done) begin bad++; $display("FAIL fullpop_timeout got=no_accept want=accept"); end
        for (int c = 0; c < 5 * NBITS * CPB + 8; c++) begin
            step(1'b0, 8'h00, 1'b0);
            total++; if (TX !== m_tx)       begin bad++; $display("FAIL fullpop_drain_tx cyc=%0d got=%b want=%b", c, TX, m_tx); end
            total++; if (level !== m_level) begin bad++; $display("FAIL fullpop_drain_level cyc=%0d got=%0d want=%0d", c, level, m_level); end
        end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL fullpop_idle got=%b want=0", busy); end
    endtask

    task automatic test_reset_mid();
        step(1'b1, 8'hA1, 1'b0);
        step(1'b1, 8'hB2, 1'b0);
        step(1'b1, 8'hC3, 1'b0);
        for (int c = 0; c < 16; c++) step(1'b0, 8'h00, 1'b0);
        total++; if (level !== 3'd2) begin bad++; $display("FAIL midrst_queued got=%0d want=2", level); end
        step(1'b0, 8'h00, 1'b1);
        total++; if (TX !== 1'b1)    begin bad++; $display("FAIL midrst_tx got=%b want=1", TX); end
        total++; if (busy !== 1'b0)  begin bad++; $display("FAIL midrst_busy got=%b want=0", busy); end
        total++; if (level !== 3'd0) begin bad++; $display("FAIL midrst_level got=%0d want=0", level); end
        for (int c = 0; c < 60; c++) begin
            step(1'b0, 8'h00, 1'b0);
            total++; if (TX !== 1'b1) begin bad++; $display("FAIL midrst_silent cyc=%0d got=%b want=1", c, TX); end
        end
        step(1'b1, 8'h3C, 1'b0);
        for (int c = 0; c < NBITS * CPB + 4; c++) begin
            step(1'b0, 8'h00, 1'b0);
            total++; if (TX !== m_tx)     begin bad++; $display("FAIL midrst_next_tx cyc=%0d got=%b want=%b", c, TX, m_tx); end
            total++; if (busy !== m_busy) begin bad++; $display("FAIL midrst_next_busy cyc=%0d got=%b want=%b", c, busy, m_busy); end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            step(($urandom_range(0, 3) == 0), 8'($urandom), ($urandom_range(0, 299) == 0));
            total++; if (obs_rdy !== m_rdy) begin bad++; $display("FAIL rand_ready cyc=%0d got=%b want=%b", c, obs_rdy, m_rdy); end
            total++; if (TX !== m_tx)       begin bad++; $display("FAIL rand_tx cyc=%0d got=%b want=%b", c, TX, m_tx); end
            total++; if (busy !== m_busy)   begin bad++; $display("FAIL rand_busy cyc=%0d got=%b want=%b", c, busy, m_busy); end
            total++; if (level !== m_level) begin bad++; $display("FAIL rand_level cyc=%0d got=%0d want=%0d", c, level, m_level); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_full();
        test_full_pop();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
